// File: rtl/axi_tg_pkg.sv
// Shared types and constants for the AXI master traffic generator.
package axi_tg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WA   = 3'd1,
        ST_WD   = 3'd2,
        ST_WB   = 3'd3,
        ST_RA   = 3'd4,
        ST_RD   = 3'd5,
        ST_FIN  = 3'd6
    } tg_state_e;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/axi_tg_pattern.sv
// Expected data for a beat: (burst address + beat*bytes) XOR SEED, resized to DATA_WIDTH.
module axi_tg_pattern
    import axi_tg_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter logic [31:0] SEED       = 32'hA5A5_0000
) (
    input  logic [ADDR_WIDTH-1:0] burst_addr,
    input  logic [8:0]            beat,
    output logic [DATA_WIDTH-1:0] data
);

    localparam int unsigned BYTES = DATA_WIDTH / 8;

    logic [ADDR_WIDTH-1:0] beat_addr;

    assign beat_addr = burst_addr + ADDR_WIDTH'(beat) * ADDR_WIDTH'(BYTES);

    // Bits beyond either operand's width are treated as zero.
    for (genvar i = 0; i < DATA_WIDTH; i++) begin : gen_bit
        if (i < ADDR_WIDTH && i < 32) begin : gen_both
            assign data[i] = beat_addr[i] ^ SEED[i];
        end else if (i < ADDR_WIDTH) begin : gen_addr
            assign data[i] = beat_addr[i];
        end else if (i < 32) begin : gen_seed
            assign data[i] = SEED[i];
        end else begin : gen_zero
            assign data[i] = 1'b0;
        end
    end

endmodule

// File: rtl/axi_master_traffic_gen.sv
// AXI master traffic generator: writes NUM_BURSTS INCR bursts of a seeded pattern,
// reads them back and counts data/response errors.
module axi_master_traffic_gen
    import axi_tg_pkg::*;
#(
    parameter int unsigned          ID_WIDTH   = 2,
    parameter int unsigned          ADDR_WIDTH = 32,
    parameter int unsigned          DATA_WIDTH = 32,
    parameter int unsigned          BURST_LEN  = 16,
    parameter int unsigned          NUM_BURSTS = 4,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0,
    parameter logic [31:0]          SEED       = 32'hA5A5_0000,
    parameter logic [ID_WIDTH-1:0]  MASTER_ID  = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    mode,
    output logic                    busy,
    output logic                    done,
    output logic [15:0]             err_cnt,
    output logic                    MASTER_CLK,
    output logic                    MASTER_RSTN,
    output logic [ID_WIDTH-1:0]     MASTER_WR_ADDR_ID,
    output logic [ADDR_WIDTH-1:0]   MASTER_WR_ADDR,
    output logic [7:0]              MASTER_WR_ADDR_LEN,
    output logic [1:0]              MASTER_WR_ADDR_BURST,
    output logic                    MASTER_WR_ADDR_VALID,
    input  logic                    MASTER_WR_ADDR_READY,
    output logic [DATA_WIDTH-1:0]   MASTER_WR_DATA,
    output logic [DATA_WIDTH/8-1:0] MASTER_WR_STRB,
    output logic                    MASTER_WR_DATA_LAST,
    output logic                    MASTER_WR_DATA_VALID,
    input  logic                    MASTER_WR_DATA_READY,
    input  logic [ID_WIDTH-1:0]     MASTER_WR_BACK_ID,
    input  logic [1:0]              MASTER_WR_BACK_RESP,
    input  logic                    MASTER_WR_BACK_VALID,
    output logic                    MASTER_WR_BACK_READY,
    output logic [ID_WIDTH-1:0]     MASTER_RD_ADDR_ID,
    output logic [ADDR_WIDTH-1:0]   MASTER_RD_ADDR,
    output logic [7:0]              MASTER_RD_ADDR_LEN,
    output logic [1:0]              MASTER_RD_ADDR_BURST,
    output logic                    MASTER_RD_ADDR_VALID,
    input  logic                    MASTER_RD_ADDR_READY,
    input  logic [ID_WIDTH-1:0]     MASTER_RD_BACK_ID,
    input  logic [DATA_WIDTH-1:0]   MASTER_RD_BACK_DATA,
    input  logic [1:0]              MASTER_RD_BACK_DATA_RESP,
    input  logic                    MASTER_RD_BACK_DATA_LAST,
    input  logic                    MASTER_RD_BACK_DATA_VALID,
    output logic                    MASTER_RD_DATA_READY
);

    localparam int unsigned BYTES = DATA_WIDTH / 8;
    localparam int unsigned BW    = $clog2(NUM_BURSTS + 1);
    localparam logic [8:0]    LAST_BEAT  = 9'(BURST_LEN - 1);
    localparam logic [BW-1:0] LAST_BURST = BW'(NUM_BURSTS - 1);

    function automatic logic [ADDR_WIDTH-1:0] calc_burst_addr(input logic [BW-1:0] b);
        return BASE_ADDR + ADDR_WIDTH'(b) * ADDR_WIDTH'(BURST_LEN * BYTES);
    endfunction

    tg_state_e             state_q, state_d;
    logic [BW-1:0]         b_q, b_d;
    logic [8:0]            k_q, k_d;
    logic [15:0]           err_q, err_d;
    logic                  done_q, done_d;
    logic                  busy_q, busy_d;
    logic [ID_WIDTH-1:0]   id_q, id_d;
    logic [7:0]            len_q, len_d;
    logic [1:0]            burst_q, burst_d;
    logic                  aw_valid_q, aw_valid_d;
    logic [ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d;
    logic                  w_valid_q, w_valid_d;
    logic [DATA_WIDTH-1:0] w_data_q, w_data_d;
    logic [BYTES-1:0]      strb_q, strb_d;
    logic                  w_last_q, w_last_d;
    logic                  b_ready_q, b_ready_d;
    logic                  ar_valid_q, ar_valid_d;
    logic [ADDR_WIDTH-1:0] ar_addr_q, ar_addr_d;
    logic                  r_ready_q, r_ready_d;

    logic [8:0]            beat_sel;
    logic [DATA_WIDTH-1:0] pat_data;
    logic                  beat_err;

    // One pattern generator: the write path looks one beat ahead, the read path checks the current beat.
    always_comb begin
        beat_sel = 9'd0;
        if (state_q == ST_WD) beat_sel = k_q + 9'd1;
        else if (state_q == ST_RD) beat_sel = k_q;
    end

    axi_tg_pattern #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .SEED       (SEED)
    ) u_pattern (
        .burst_addr (calc_burst_addr(b_q)),
        .beat       (beat_sel),
        .data       (pat_data)
    );

    assign beat_err = (MASTER_RD_BACK_DATA != pat_data)
                    | (MASTER_RD_BACK_DATA_RESP != AXI_RESP_OKAY)
                    | (MASTER_RD_BACK_DATA_LAST != (k_q == LAST_BEAT))
                    | (MASTER_RD_BACK_ID != MASTER_ID);

    always_comb begin
        state_d    = state_q;
        b_d        = b_q;
        k_d        = k_q;
        err_d      = err_q;
        done_d     = 1'b0;
        id_d       = id_q;
        len_d      = len_q;
        burst_d    = burst_q;
        aw_valid_d = aw_valid_q;
        aw_addr_d  = aw_addr_q;
        w_valid_d  = w_valid_q;
        w_data_d   = w_data_q;
        strb_d     = strb_q;
        w_last_d   = w_last_q;
        b_ready_d  = b_ready_q;
        ar_valid_d = ar_valid_q;
        ar_addr_d  = ar_addr_q;
        r_ready_d  = r_ready_q;
        case (state_q)
            ST_IDLE: if (start) begin
                err_d   = '0;
                b_d     = '0;
                k_d     = '0;
                id_d    = MASTER_ID;
                len_d   = 8'(BURST_LEN - 1);
                burst_d = AXI_BURST_INCR;
                if (!mode) begin
                    state_d    = ST_WA;
                    aw_valid_d = 1'b1;
                    aw_addr_d  = calc_burst_addr('0);
                end else begin
                    state_d    = ST_RA;
                    ar_valid_d = 1'b1;
                    ar_addr_d  = calc_burst_addr('0);
                end
            end
            ST_WA: if (aw_valid_q && MASTER_WR_ADDR_READY) begin
                aw_valid_d = 1'b0;
                state_d    = ST_WD;
                w_valid_d  = 1'b1;
                w_data_d   = pat_data;
                strb_d     = '1;
                w_last_d   = (LAST_BEAT == 9'd0);
                k_d        = '0;
            end
            ST_WD: if (w_valid_q && MASTER_WR_DATA_READY) begin
                if (w_last_q) begin
                    w_valid_d = 1'b0;
                    w_last_d  = 1'b0;
                    b_ready_d = 1'b1;
                    state_d   = ST_WB;
                end else begin
                    k_d      = k_q + 9'd1;
                    w_data_d = pat_data;
                    w_last_d = (k_q + 9'd1 == LAST_BEAT);
                end
            end
            ST_WB: if (b_ready_q && MASTER_WR_BACK_VALID) begin
                b_ready_d = 1'b0;
                if (MASTER_WR_BACK_RESP != AXI_RESP_OKAY || MASTER_WR_BACK_ID != MASTER_ID)
                    err_d = sat_inc(err_q);
                if (b_q == LAST_BURST) begin
                    b_d        = '0;
                    state_d    = ST_RA;
                    ar_valid_d = 1'b1;
                    ar_addr_d  = calc_burst_addr('0);
                end else begin
                    b_d        = b_q + BW'(1);
                    state_d    = ST_WA;
                    aw_valid_d = 1'b1;
                    aw_addr_d  = calc_burst_addr(b_q + BW'(1));
                end
            end
            ST_RA: if (ar_valid_q && MASTER_RD_ADDR_READY) begin
                ar_valid_d = 1'b0;
                r_ready_d  = 1'b1;
                k_d        = '0;
                state_d    = ST_RD;
            end
            // Beats are counted locally, so a misplaced LAST is an error but does not end the burst.
            ST_RD: if (r_ready_q && MASTER_RD_BACK_DATA_VALID) begin
                if (beat_err) err_d = sat_inc(err_q);
                if (k_q == LAST_BEAT) begin
                    r_ready_d = 1'b0;
                    if (b_q == LAST_BURST) begin
                        b_d     = '0;
                        state_d = ST_FIN;
                        done_d  = 1'b1;
                    end else begin
                        b_d        = b_q + BW'(1);
                        state_d    = ST_RA;
                        ar_valid_d = 1'b1;
                        ar_addr_d  = calc_burst_addr(b_q + BW'(1));
                    end
                end else begin
                    k_d = k_q + 9'd1;
                end
            end
            ST_FIN: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            b_q        <= '0;
            k_q        <= '0;
            err_q      <= '0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            id_q       <= '0;
            len_q      <= '0;
            burst_q    <= '0;
            aw_valid_q <= 1'b0;
            aw_addr_q  <= '0;
            w_valid_q  <= 1'b0;
            w_data_q   <= '0;
            strb_q     <= '0;
            w_last_q   <= 1'b0;
            b_ready_q  <= 1'b0;
            ar_valid_q <= 1'b0;
            ar_addr_q  <= '0;
            r_ready_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            b_q        <= b_d;
            k_q        <= k_d;
            err_q      <= err_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
            id_q       <= id_d;
            len_q      <= len_d;
            burst_q    <= burst_d;
            aw_valid_q <= aw_valid_d;
            aw_addr_q  <= aw_addr_d;
            w_valid_q  <= w_valid_d;
            w_data_q   <= w_data_d;
            strb_q     <= strb_d;
            w_last_q   <= w_last_d;
            b_ready_q  <= b_ready_d;
            ar_valid_q <= ar_valid_d;
            ar_addr_q  <= ar_addr_d;
            r_ready_q  <= r_ready_d;
        end
    end

    assign busy                 = busy_q;
    assign done                 = done_q;
    assign err_cnt              = err_q;
    assign MASTER_CLK           = clk;
    assign MASTER_RSTN          = ~rst;
    assign MASTER_WR_ADDR_ID    = id_q;
    assign MASTER_WR_ADDR       = aw_addr_q;
    assign MASTER_WR_ADDR_LEN   = len_q;
    assign MASTER_WR_ADDR_BURST = burst_q;
    assign MASTER_WR_ADDR_VALID = aw_valid_q;
    assign MASTER_WR_DATA       = w_data_q;
    assign MASTER_WR_STRB       = strb_q;
    assign MASTER_WR_DATA_LAST  = w_last_q;
    assign MASTER_WR_DATA_VALID = w_valid_q;
    assign MASTER_WR_BACK_READY = b_ready_q;
    assign MASTER_RD_ADDR_ID    = id_q;
    assign MASTER_RD_ADDR       = ar_addr_q;
    assign MASTER_RD_ADDR_LEN   = len_q;
    assign MASTER_RD_ADDR_BURST = burst_q;
    assign MASTER_RD_ADDR_VALID = ar_valid_q;
    assign MASTER_RD_DATA_READY = r_ready_q;

endmodule

// File: tb/tb_axi_master_traffic_gen.sv
// Randomized memory-slave bench with a scoreboard of expected AXI traffic and error counts.
module tb_axi_master_traffic_gen;

    localparam logic [31:0] SEED0 = 32'hA5A5_0000;
    localparam int          BL    = 16;
    localparam int          NB    = 4;
    localparam logic [31:0] BASE1 = 32'h0000_0100;
    localparam logic [31:0] SEED1 = 32'h1234_5678;

    typedef struct { logic [31:0] addr; int len; } rb_t;

    logic clk = 1'b0;
    logic rst = 1'b1, start = 1'b0, mode = 1'b0, start1 = 1'b0;

    // DUT0 (defaults)
    logic busy0, done0, mclk0, mrstn0;
    logic [15:0] err0;
    logic [1:0] awid0, awburst0, arid0, arburst0;
    logic [31:0] awaddr0, araddr0, wdata0;
    logic [7:0] awlen0, arlen0;
    logic [3:0] wstrb0;
    logic awvalid0, wvalid0, wlast0, bready0, arvalid0, rready0;
    logic awready0 = 1'b0, wready0 = 1'b0, arready0 = 1'b0;
    logic bvalid0 = 1'b0, rvalid0 = 1'b0, rlast0 = 1'b0;
    logic [1:0] bid0 = 2'b0, bresp0 = 2'b0, rid0 = 2'b0, rresp0 = 2'b0;
    logic [31:0] rdata0 = 32'h0;

    // DUT1 (single-beat read-only)
    logic busy1, done1, mclk1, mrstn1;
    logic [15:0] err1;
    logic [1:0] awid1, awburst1, arid1, arburst1;
    logic [31:0] awaddr1, araddr1, wdata1;
    logic [7:0] awlen1, arlen1;
    logic [3:0] wstrb1;
    logic awvalid1, wvalid1, wlast1, bready1, arvalid1, rready1;
    logic arready1 = 1'b0, rvalid1 = 1'b0, rlast1 = 1'b0;
    logic [1:0] rid1 = 2'b0, rresp1 = 2'b0;
    logic [31:0] rdata1 = 32'h0;

    int n_chk = 0, n_pass = 0;

    // slave / scoreboard state for DUT0
    bit bp = 0;
    int flip_beat = -1, bad_b = -1;
    int wcnt = 0, rcnt = 0, gbeat = 0, b_idx = 0, b_pend = 0, wk = 0, rk = 0, done_cnt0 = 0;
    logic [31:0] mem [logic [31:0]];
    logic [31:0] wq[$], aw_log[$], exp_aw[$], exp_ar[$];
    logic [32:0] exp_w[$];
    rb_t rq[$];
    int exp_done = 0;
    bit b_fired = 0, r_fired = 0, prev_done0 = 0, aw_stall = 0, w_stall = 0, ar_stall = 0;
    logic [43:0] aw_hold, ar_hold;
    logic [36:0] w_hold;

    // DUT1 slave state
    int ar1_cnt = 0, r1_cnt = 0, done1_cnt = 0;
    bit ar1_pend = 0, r1_fired = 0, wr1_seen = 0;

    always #5 clk = ~clk;

    axi_master_traffic_gen dut0 (
        .clk(clk), .rst(rst), .start(start), .mode(mode),
        .busy(busy0), .done(done0), .err_cnt(err0),
        .MASTER_CLK(mclk0), .MASTER_RSTN(mrstn0),
        .MASTER_WR_ADDR_ID(awid0), .MASTER_WR_ADDR(awaddr0), .MASTER_WR_ADDR_LEN(awlen0),
        .MASTER_WR_ADDR_BURST(awburst0), .MASTER_WR_ADDR_VALID(awvalid0), .MASTER_WR_ADDR_READY(awready0),
        .MASTER_WR_DATA(wdata0), .MASTER_WR_STRB(wstrb0), .MASTER_WR_DATA_LAST(wlast0),
        .MASTER_WR_DATA_VALID(wvalid0), .MASTER_WR_DATA_READY(wready0),
        .MASTER_WR_BACK_ID(bid0), .MASTER_WR_BACK_RESP(bresp0), .MASTER_WR_BACK_VALID(bvalid0),
        .MASTER_WR_BACK_READY(bready0),
        .MASTER_RD_ADDR_ID(arid0), .MASTER_RD_ADDR(araddr0), .MASTER_RD_ADDR_LEN(arlen0),
        .MASTER_RD_ADDR_BURST(arburst0), .MASTER_RD_ADDR_VALID(arvalid0), .MASTER_RD_ADDR_READY(arready0),
        .MASTER_RD_BACK_ID(rid0), .MASTER_RD_BACK_DATA(rdata0), .MASTER_RD_BACK_DATA_RESP(rresp0),
        .MASTER_RD_BACK_DATA_LAST(rlast0), .MASTER_RD_BACK_DATA_VALID(rvalid0),
        .MASTER_RD_DATA_READY(rready0)
    );

    axi_master_traffic_gen #(.BURST_LEN(1), .NUM_BURSTS(1), .BASE_ADDR(BASE1), .SEED(SEED1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .mode(1'b1),
        .busy(busy1), .done(done1), .err_cnt(err1),
        .MASTER_CLK(mclk1), .MASTER_RSTN(mrstn1),
        .MASTER_WR_ADDR_ID(awid1), .MASTER_WR_ADDR(awaddr1), .MASTER_WR_ADDR_LEN(awlen1),
        .MASTER_WR_ADDR_BURST(awburst1), .MASTER_WR_ADDR_VALID(awvalid1), .MASTER_WR_ADDR_READY(1'b0),
        .MASTER_WR_DATA(wdata1), .MASTER_WR_STRB(wstrb1), .MASTER_WR_DATA_LAST(wlast1),
        .MASTER_WR_DATA_VALID(wvalid1), .MASTER_WR_DATA_READY(1'b0),
        .MASTER_WR_BACK_ID(2'b00), .MASTER_WR_BACK_RESP(2'b00), .MASTER_WR_BACK_VALID(1'b0),
        .MASTER_WR_BACK_READY(bready1),
        .MASTER_RD_ADDR_ID(arid1), .MASTER_RD_ADDR(araddr1), .MASTER_RD_ADDR_LEN(arlen1),
        .MASTER_RD_ADDR_BURST(arburst1), .MASTER_RD_ADDR_VALID(arvalid1), .MASTER_RD_ADDR_READY(arready1),
        .MASTER_RD_BACK_ID(rid1), .MASTER_RD_BACK_DATA(rdata1), .MASTER_RD_BACK_DATA_RESP(rresp1),
        .MASTER_RD_BACK_DATA_LAST(rlast1), .MASTER_RD_BACK_DATA_VALID(rvalid1),
        .MASTER_RD_DATA_READY(rready1)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // DUT0 memory slave + monitor. Valid/ready for the coming edge are settled here, so a
    // handshake seen now is the one the DUT will take at the next posedge.
    always @(negedge clk) begin
        if (rst) begin
            awready0 = 0; wready0 = 0; arready0 = 0;
            bvalid0 = 0; rvalid0 = 0; rlast0 = 0;
            wq.delete(); rq.delete();
            b_pend = 0; wk = 0; rk = 0;
            b_fired = 0; r_fired = 0;
            aw_stall = 0; w_stall = 0; ar_stall = 0;
        end else begin
            if (aw_stall) chk("aw_hold", {awvalid0, awid0, awaddr0, awlen0, awburst0}, {1'b1, aw_hold});
            if (w_stall)  chk("w_hold", {wvalid0, wdata0, wstrb0, wlast0}, {1'b1, w_hold});
            if (ar_stall) chk("ar_hold", {arvalid0, arid0, araddr0, arlen0, arburst0}, {1'b1, ar_hold});

            if (start && !busy0) begin
                wcnt = 0; rcnt = 0; gbeat = 0; b_idx = 0;
                aw_log.delete();
            end
            if (b_fired) begin bvalid0 = 0; b_fired = 0; end
            if (r_fired) begin rvalid0 = 0; rlast0 = 0; r_fired = 0; end

            awready0 = bp ? 1'($urandom_range(1, 0)) : 1'b1;
            wready0  = bp ? 1'($urandom_range(1, 0)) : 1'b1;
            arready0 = bp ? 1'($urandom_range(1, 0)) : 1'b1;

            if (!bvalid0 && b_pend > 0 && (!bp || $urandom_range(1, 0) == 1)) begin
                bvalid0 = 1;
                bid0    = 2'b00;
                bresp0  = (b_idx == bad_b) ? 2'b10 : 2'b00;
            end
            if (!rvalid0 && rq.size() > 0 && (!bp || $urandom_range(1, 0) == 1)) begin
                logic [31:0] a;
                a = rq[0].addr + 32'(4 * rk);
                rvalid0 = 1;
                rdata0  = mem.exists(a) ? mem[a] : 32'h0;
                if (gbeat == flip_beat) rdata0[0] = ~rdata0[0];
                rlast0  = (rk == rq[0].len);
                rresp0  = 2'b00;
                rid0    = 2'b00;
            end

            if (awvalid0 && awready0) begin
                if (exp_aw.size() > 0)
                    chk("aw_payload", {awid0, awaddr0, awlen0, awburst0}, {2'b00, exp_aw.pop_front(), 8'(BL - 1), 2'b01});
                else chk("aw_unexpected", 1, 0);
                aw_log.push_back(awaddr0);
                wq.push_back(awaddr0);
            end
            if (wvalid0 && wready0) begin
                if (exp_w.size() > 0) chk("w_beat", {wlast0, wdata0, wstrb0}, {exp_w.pop_front(), 4'hF});
                else chk("w_unexpected", 1, 0);
                if (wq.size() > 0) begin
                    mem[wq[0] + 32'(4 * wk)] = wdata0;
                    wk++;
                    if (wlast0) begin void'(wq.pop_front()); wk = 0; b_pend++; end
                end else chk("w_before_aw", 1, 0);
                wcnt++;
            end
            if (bvalid0 && bready0) begin
                b_fired = 1; b_pend--; b_idx++;
            end
            if (arvalid0 && arready0) begin
                if (exp_ar.size() > 0)
                    chk("ar_payload", {arid0, araddr0, arlen0, arburst0}, {2'b00, exp_ar.pop_front(), 8'(BL - 1), 2'b01});
                else chk("ar_unexpected", 1, 0);
                rq.push_back('{addr: araddr0, len: int'(arlen0)});
            end
            if (rvalid0 && rready0) begin
                r_fired = 1; rcnt++; gbeat++;
                if (rk == rq[0].len) begin void'(rq.pop_front()); rk = 0; end
                else rk++;
            end

            if (done0) begin
                chk("done_expected", exp_done > 0, 1);
                if (exp_done > 0) exp_done--;
                chk("done_pulse", prev_done0, 0);
                done_cnt0++;
            end
            prev_done0 = done0;
            aw_stall = awvalid0 && !awready0;
            aw_hold  = {awid0, awaddr0, awlen0, awburst0};
            w_stall  = wvalid0 && !wready0;
            w_hold   = {wdata0, wstrb0, wlast0};
            ar_stall = arvalid0 && !arready0;
            ar_hold  = {arid0, araddr0, arlen0, arburst0};
        end
    end

    // DUT1 slave: one preloaded word at BASE1.
    always @(negedge clk) begin
        if (rst) begin
            arready1 = 0; rvalid1 = 0; rlast1 = 0; ar1_pend = 0; r1_fired = 0;
        end else begin
            if (start1 && !busy1) begin ar1_cnt = 0; r1_cnt = 0; wr1_seen = 0; end
            if (r1_fired) begin rvalid1 = 0; rlast1 = 0; r1_fired = 0; end
            arready1 = 1;
            if (ar1_pend && !rvalid1) begin
                rvalid1 = 1; rdata1 = BASE1 ^ SEED1; rlast1 = 1; rresp1 = 2'b00; rid1 = 2'b00;
            end
            if (arvalid1 && arready1) begin
                chk("ar1_payload", {arid1, araddr1, arlen1, arburst1}, {2'b00, BASE1, 8'd0, 2'b01});
                ar1_cnt++; ar1_pend = 1;
            end
            if (rvalid1 && rready1) begin r1_cnt++; ar1_pend = 0; r1_fired = 1; end
            if (awvalid1 || wvalid1 || bready1) wr1_seen = 1;
            if (done1) done1_cnt++;
        end
    end

    task automatic push_expected(input bit m);
        for (int b = 0; b < NB; b++) begin
            logic [31:0] ba;
            ba = 32'(b * BL * 4);
            if (!m) begin
                exp_aw.push_back(ba);
                for (int k = 0; k < BL; k++) exp_w.push_back({k == BL - 1, (ba + 32'(4 * k)) ^ SEED0});
            end
            exp_ar.push_back(ba);
        end
        exp_done++;
    endtask

    task automatic clear_expected();
        exp_aw.delete(); exp_w.delete(); exp_ar.delete(); exp_done = 0;
    endtask

    task automatic run0(input bit m, input int exp_err, input bit poke);
        int d0;
        push_expected(m);
        d0 = done_cnt0;
        mode = m; start = 1; tick; start = 0;
        if (poke) begin
            for (int i = 0; i < 2000 && rcnt < 20; i++) tick;
            chk("poke_reached", rcnt >= 20, 1);
            start = 1; tick; start = 0;
        end
        for (int i = 0; i < 4000 && done_cnt0 == d0; i++) tick;
        chk("run_done", done_cnt0 - d0, 1);
        tick;
        chk("err_cnt", err0, exp_err);
        chk("busy_after", busy0, 0);
        chk("wbeats", wcnt, m ? 0 : NB * BL);
        chk("rbeats", rcnt, NB * BL);
        chk("sb_empty", exp_aw.size() + exp_w.size() + exp_ar.size() + exp_done, 0);
        clear_expected();
    endtask

    initial begin
        tick; tick;
        chk("reset_ctl", {busy0, done0, err0, mrstn0, busy1, done1, err1}, 0);
        chk("reset_hs", {awvalid0, wvalid0, wlast0, bready0, arvalid0, rready0, arvalid1, rready1}, 0);
        chk("reset_bus", {awaddr0, wdata0, awid0, araddr0}, 0);
        rst = 0; tick;
        chk("rstn_release", mrstn0, 1);

        run0(0, 0, 0);
        chk("aw2_addr", (aw_log.size() > 1) ? aw_log[1] : 32'hDEAD_BEEF, 32'h40);

        flip_beat = 5;
        run0(0, 1, 1);
        flip_beat = -1;

        run0(1, 0, 0);

        bp = 1;
        run0(0, 0, 0);
        bp = 0;

        bad_b = 2;
        run0(0, 1, 0);
        bad_b = -1;

        push_expected(0);
        mode = 0; start = 1; tick; start = 0;
        for (int i = 0; i < 500 && wcnt < 7; i++) tick;
        chk("reach_wd7", {wcnt == 7, wvalid0}, 2'b11);
        rst = 1; tick;
        chk("abort_state", {awvalid0, wvalid0, arvalid0, bready0, rready0, busy0, done0, err0}, 0);
        rst = 0; clear_expected(); tick;
        run0(0, 0, 0);

        begin
            int d1;
            d1 = done1_cnt;
            start1 = 1; tick; start1 = 0;
            for (int i = 0; i < 200 && done1_cnt == d1; i++) tick;
            tick;
            chk("single_done", done1_cnt - d1, 1);
            chk("single_err", err1, 0);
            chk("single_beats", {8'(ar1_cnt), 8'(r1_cnt), 7'd0, wr1_seen}, {8'd1, 8'd1, 8'd0});
            chk("single_busy", busy1, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/axi_master_traffic_gen.md
AXI_MASTER_TRAFFIC_GEN -- requirements
Module: axi_master_traffic_gen

Interface
REQ-001 Parameters SHALL be, one per line, as name, default, meaning:
- ID_WIDTH, 2, AXI ID width.
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, data width; STRB width = DATA_WIDTH/8.
- BURST_LEN, 16, beats per burst, 1..256.
- NUM_BURSTS, 4, bursts per run, >=1.
- BASE_ADDR, 0, first byte address of a run.
- SEED, 32'hA5A5_0000, data pattern XOR key.
- MASTER_ID, 0, ID driven on AW and AR.
REQ-002 Ports SHALL be, one per line, as name, direction, width, meaning:
- clk, in, 1, sole clock.
- rst, in, 1, synchronous active-high reset.
- start, in, 1, run request pulse.
- mode, in, 1, 0 = write then read-check; 1 = read-check only.
- busy, out, 1, run in progress.
- done, out, 1, one-cycle pulse at run end.
- err_cnt, out, 16, saturating mismatch/response-error count.
- MASTER_CLK, out, 1, = clk.
- MASTER_RSTN, out, 1, = ~rst.
- MASTER_WR_ADDR_ID/_ADDR/_LEN/_BURST/_VALID, out, ID_WIDTH/ADDR_WIDTH/8/2/1; MASTER_WR_ADDR_READY, in, 1.
- MASTER_WR_DATA/_STRB/_DATA_LAST/_DATA_VALID, out, DATA_WIDTH/DATA_WIDTH/8/1/1; MASTER_WR_DATA_READY, in, 1.
- MASTER_WR_BACK_ID/_RESP/_VALID, in, ID_WIDTH/2/1; MASTER_WR_BACK_READY, out, 1.
- MASTER_RD_ADDR_ID/_ADDR/_LEN/_BURST/_VALID, out, as write address; MASTER_RD_ADDR_READY, in, 1.
- MASTER_RD_BACK_ID/_DATA/_DATA_RESP/_DATA_LAST/_DATA_VALID, in, ID_WIDTH/DATA_WIDTH/2/1/1; MASTER_RD_DATA_READY, out, 1.
REQ-003 One clock, clk; reset rst, synchronous, active-high.

Function
REQ-004 FSM states: IDLE, WA, WD, WB, RA, RD, FIN.
REQ-005 IDLE: start=1 clears err_cnt and burst index b; next state WA if mode=0, else RA.
REQ-006 start while busy=1 SHALL be ignored.
REQ-007 Burst b address = BASE_ADDR + b*BURST_LEN*(DATA_WIDTH/8); LEN = BURST_LEN-1; BURST = 2'b01 (INCR); ID = MASTER_ID.
REQ-008 WA: assert WR_ADDR_VALID; on VALID&READY go to WD.
REQ-009 WD: beat k data = (burst address + k*DATA_WIDTH/8) XOR SEED, zero-extended/truncated to DATA_WIDTH; STRB all ones; DATA_LAST on k = BURST_LEN-1; k advances only on VALID&READY.
REQ-010 WB: BACK_READY=1; on BACK_VALID, RESP != 2'b00 or BACK_ID != MASTER_ID adds 1 to err_cnt; then b+1; next WA, or RA with b=0 after the last burst.
REQ-011 RA/RD mirror WA/WD: RD_DATA_READY=1 in RD; each accepted beat compares against the REQ-009 pattern; each mismatch, RESP != 0, or LAST misplaced adds 1 (max 1 per beat).
REQ-012 After the last RD burst: FIN pulses done for one cycle, then IDLE.
REQ-013 VALID, once asserted, SHALL hold with stable payload until READY; at most one transaction outstanding.
REQ-014 READY may be high in the same cycle VALID rises; zero-wait handshakes give one beat per cycle.
REQ-015 err_cnt SHALL saturate at 16'hFFFF.
REQ-016 busy = (state != IDLE).
REQ-017 All outputs other than MASTER_CLK/MASTER_RSTN SHALL be registered.

Reset
REQ-018 rst=1 at an edge: state IDLE, all VALID/READY/LAST 0, address/data/ID buses 0, busy 0, done 0, err_cnt 0.
REQ-019 Reset mid-burst SHALL abort immediately; holding VALID low is permitted only on reset.

Structure
REQ-020 Package axi_tg_pkg holds the state enum, AXI_BURST_INCR = 2'b01 and AXI_RESP_OKAY = 2'b00.
REQ-021 One sub-module, axi_tg_pattern: combinational address/beat to expected-data function, shared by the write path and the read-check path.

Verification
REQ-022 Zero-wait memory slave, defaults, mode=0, start -> 64 write beats, 64 read beats, done pulse, err_cnt=0, 2nd-burst AW address 0x40.
REQ-023 Slave flips bit 0 of read beat 5 -> err_cnt=1.
REQ-024 Random READY backpressure (50%) on every channel -> VALID/payload stable until READY, err_cnt=0.
REQ-025 BRESP=2'b10 on burst 2 -> err_cnt=1; run still completes.
REQ-026 rst during WD beat 7 -> next cycle all VALID=0, busy=0; a fresh start completes, err_cnt=0.
REQ-027 BURST_LEN=1, NUM_BURSTS=1, mode=1 over preloaded memory -> single-beat read with LAST=1, done pulse, err_cnt=0.
